// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg
// Shared definitions for the pipelined adder/subtractor slice.
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   op_e                   : operation select (add / subtract)
//   calcChunk()            : bits resolved per pipeline stage
//   isValidSplit()         : legality of a WIDTH/STAGES split
//   fullAdd()              : one-bit full adder, returns {carry, sum}
package pipelined_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int calcChunk(input int width, input int stages);
    return width / stages;
  endfunction

  // The carry chain is cut into equal slices, so the width must divide evenly
  function automatic bit isValidSplit(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  function automatic logic [1:0] fullAdd(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// rca_chunk
// Purely combinational N-bit ripple-carry adder built from full adders.
// One instance resolves one slice of the wide add inside pipelined_adder.
//   a, b : N-bit slice operands
//   ci   : carry into the least significant bit of the slice
//   s    : N-bit slice sum
//   co   : carry out of the most significant bit of the slice
module rca_chunk
  import pipelined_adder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0] w_c;

  // Ripple the carry bit by bit; kept in one block so the chain is a single
  // combinational path rather than a web of separate bit assignments.
  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = ci;
    for (int i = 0; i < N; i++) begin
      {w_c[i+1], s[i]} = fullAdd(a[i], b[i], w_c[i]);
    end
  end

  assign co = w_c[N];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder
// Pipelined carry-chain adder/subtractor with valid/ready handshakes.
// A WIDTH-bit add is split into STAGES slices of CHUNK bits; stage k resolves
// slice k using the carry registered by stage k-1. Every stage owns a valid
// bit, so bubbles collapse and backpressure stalls without losing operations.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready is combinational)
//   a, b, cin, sub      : operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready : output handshake
//   sum, cout, ovf      : result, carry out (no-borrow for sub), signed overflow
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = calcChunk(WIDTH, STAGES);

  if (!isValidSplit(WIDTH, STAGES)) begin : g_badSplit
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  op_e              w_op;
  logic [WIDTH-1:0] w_bEff;
  logic             w_c0;

  // Per-stage pipeline state. r_a/r_b carry the raw operands forward so later
  // stages can reach their slice; r_sum accumulates the resolved slices.
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;

  // What each stage would load this cycle, seen from its upstream neighbour
  logic [WIDTH-1:0]  w_upA     [STAGES];
  logic [WIDTH-1:0]  w_upB     [STAGES];
  logic [WIDTH-1:0]  w_upSum   [STAGES];
  logic [WIDTH-1:0]  w_nextSum [STAGES];
  logic [STAGES-1:0] w_upC;
  logic [STAGES-1:0] w_upV;
  logic [STAGES-1:0] w_co;
  logic [CHUNK-1:0]  w_s [STAGES];
  logic [STAGES:0]   w_rdy;

  // Subtraction is a + ~b + 1, so the +1 rides in as the initial carry
  assign w_op   = op_e'(sub);
  assign w_bEff = (w_op == OP_SUB) ? ~b : b;
  assign w_c0   = (w_op == OP_SUB) ? 1'b1 : cin;

  // Stage 0 is fed from the ports, every later stage from the register set
  // of the stage in front of it.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_upA[k]   = '0;
      w_upB[k]   = '0;
      w_upSum[k] = '0;
    end
    w_upC = '0;
    w_upV = '0;

    w_upA[0]   = a;
    w_upB[0]   = w_bEff;
    w_upSum[0] = '0;
    w_upC[0]   = w_c0;
    w_upV[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_upA[k]   = r_a[k-1];
      w_upB[k]   = r_b[k-1];
      w_upSum[k] = r_sum[k-1];
      w_upC[k]   = r_c[k-1];
      w_upV[k]   = r_v[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    rca_chunk #(
      .N(CHUNK)
    ) u_rca (
      .a (w_upA[k][k*CHUNK +: CHUNK]),
      .b (w_upB[k][k*CHUNK +: CHUNK]),
      .ci(w_upC[k]),
      .s (w_s[k]),
      .co(w_co[k])
    );
  end

  // Lower slices pass through untouched; this stage drops its own slice in
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_nextSum[k] = w_upSum[k];
      w_nextSum[k][k*CHUNK +: CHUNK] = w_s[k];
    end
  end

  // Ready ripples back from the consumer: a stage can take new data if it is
  // empty or if whatever it holds is moving on this cycle.
  always_comb begin
    w_rdy         = '0;
    w_rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_rdy[k] = !r_v[k] || w_rdy[k+1];
    end
  end

  assign in_ready = w_rdy[0];

  // All stage registers advance together. A ready stage copies its upstream
  // valid bit (clearing on a bubble) and only captures data for real work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      r_c <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_v[k] <= w_upV[k];
          if (w_upV[k]) begin
            r_a[k]   <= w_upA[k];
            r_b[k]   <= w_upB[k];
            r_c[k]   <= w_co[k];
            r_sum[k] <= w_nextSum[k];
          end
        end
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign cout      = r_c[STAGES-1];

  // Signed overflow: like-signed operands producing an opposite-signed result
  assign ovf = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1]) &&
               (r_sum[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined carry-chain adder/subtractor with a valid/ready handshake on input and output. A WIDTH-bit add is split into STAGES equal chunks, and each pipeline stage resolves one chunk's ripple carry. Each stage holds its own valid bit, so backpressure stalls the pipeline without losing operations and empty stages (bubbles) collapse. Used as the datapath arithmetic unit where a single-cycle 32-bit ripple adder limits fmax.

Parameters:
WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
STAGES, 4, number of pipeline stages; CHUNK = WIDTH/STAGES bits resolved per stage; 1 <= STAGES <= WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand set presented
in_ready  output  1  block can accept the operand set this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry in; ignored when sub=1
sub  input  1  0: a+b+cin, 1: a-b
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  result
cout  output  1  carry out of the MSB; for sub, 1 = no borrow
ovf  output  1  signed (two's complement) overflow

Behaviour:
- Reset (async, rst=1): all stage valid bits clear, so out_valid=0 immediately. sum, cout and ovf are 0. in_ready follows the combinational rule below, so it is 1 while reset is held and out_ready=1. Operations in flight are discarded; no output is produced for them after rst deasserts.
- Operand preparation at input: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1):
  - Registers chunk k of the result: a[k]+b_eff[k]+carry, where carry is c0 for k=0 and the registered carry from stage k-1 otherwise.
  - Registers the sums of chunks below k, passed forward unchanged.
  - Registers the raw a and b_eff chunks above k, delayed for later stages.
  - Registers its own valid bit.
  - The sign bits a[MSB] and b_eff[MSB] travel with the operation for ovf.
- Outputs come from the last stage:
  - cout = carry out of the top chunk.
  - ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb).
- Handshake:
  - A transfer happens on a clock edge where valid && ready.
  - Per-stage ready: r_STAGES = out_ready; r_k = !v_k || r_{k+1}; in_ready = r_0 (combinational chain).
  - Stage k loads from stage k-1 (or from the input for k=0) when r_k=1.
  - When r_k=1 and the upstream is not valid, v_k clears.
- Latency: exactly STAGES cycles from the accepting edge to out_valid, with out_ready held at 1.
- Throughput: one operation per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, sum, cout and ovf are held stable. Upstream stages fill any bubbles, then in_ready drops.
- Ordering: results emerge in acceptance order. No loss and no duplication under any out_ready pattern.
- Simultaneous events: accept and emit on the same edge is legal when the pipeline is full and out_ready=1.
- Wrap-around: the sum is modulo 2^WIDTH; overflow is reported only through cout and ovf.
- STAGES=1: the block degenerates to a single registered RCA with the same handshake.
- Inputs a, b, cin and sub are sampled only on accepting edges. Their values when in_valid=0 are don't-care.

Decomposition:
- Shared package: CHUNK = WIDTH/STAGES, derived as a localparam; an elaboration-time check that WIDTH % STAGES == 0.
- One sub-module, rca_chunk:
  - Purely combinational CHUNK-bit ripple adder built from full adders (inputs a, b, ci; outputs s, co).
  - Instantiated once per stage through a generate loop.
  - The pipeline registers and handshake live in pipelined_adder.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1: a=0x00000005, b=0x00000002, cin=0, sub=0 -> 4 cycles later sum=0x00000007, cout=0, ovf=0.
- Back-to-back input on consecutive cycles:
  - (0x0000000F, 0x0000FFFF, cin=0) -> 0x0001000E.
  - (0x00000008, 0x00000005, cin=1) -> 0x0000000E.
  - (0x10000FFF, 0x0000FFFF, cin=1) -> 0x10010FFF.
  - Results arrive on consecutive cycles, in order.
- Carry through every stage: 0xFFFFFFFF + 0x00000000 with cin=1 -> sum=0, cout=1. Then 0x7FFFFFFF + 1 -> 0x80000000, ovf=1, cout=0.
- Subtract:
  - 5-7 -> 0xFFFFFFFE, cout=0, ovf=0.
  - 0x80000000-1 -> 0x7FFFFFFF, cout=1, ovf=1.
  - cin=1 is ignored for both.
- Backpressure: stream 8 operations (values 1+1..8+8) and hold out_ready=0 for cycles 3-8. Then:
  - in_ready drops after 4 operations are held.
  - sum stays stable at 2.
  - After release, 2,4,...,16 emerge exactly once each, in order.
- Reset mid-operation: accept 3 operations, assert rst for 1 cycle while out_ready=1.
  - out_valid drops immediately.
  - No result emerges afterward.
  - A new operation 0x3+0x4 yields 0x7 four cycles after acceptance.
